wb_accel_bridge: RTL and testbench

//   Wishbone slave directly downstream of the Caravel user-area Wishbone port, inside accelerator_top.

---
 rtl/wb_accel_bridge_if.sv | 21 ++
 rtl/wb_accel_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_wb_accel_bridge.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_accel_bridge_if.sv
// Wishbone slave-side bus bundle for wb_accel_bridge; signal names follow the Caravel user-area port.
interface wb_accel_bridge_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/wb_accel_bridge.sv
// Wishbone 4-register window bridging to a crypto core via in/out FIFOs; WB_ACCEL_LOOPBACK_EN adds an in->out loopback.
// Ack/read data one cycle after request; full input FIFO drops writes (OVF), core sees ready=0 when output FIFO full.
module wb_accel_bridge #(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n_i,
   wb_accel_bridge_if.slave  wb,
   output logic [31:0]       core_din_o,
   output logic              core_din_valid_o,
   input  logic              core_din_ready_i,
   input  logic [31:0]       core_dout_i,
   input  logic              core_dout_valid_i,
   output logic              core_dout_ready_o,
   output logic              core_start_o,
   input  logic              core_busy_i,
   output logic              irq_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LW-1:0] DEPTH = LW'(FIFO_DEPTH);

   logic        ack_q, start_q, irq_en_q, done_q, ovf_q, unf_q, busy_q;
   logic [31:0] dat_q, rdata;
   logic        hit, req, in_win;
   logic [1:0]  ofs;
   logic        wr_ctrl, wr_status, wr_din, rd_dout;
   logic        flush, lb, lb_move;

   logic [31:0]   in_mem [FIFO_DEPTH];
   logic [AW-1:0] in_wp, in_rp;
   logic [LW-1:0] in_cnt;
   logic          in_empty, in_full, in_push, in_pop;

   logic [31:0]   out_mem [FIFO_DEPTH];
   logic [AW-1:0] out_wp, out_rp;
   logic [LW-1:0] out_cnt;
   logic          out_empty, out_full, out_push, out_pop;
   logic [31:0]   out_din;

   assign hit    = (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign req    = wb.wbs_cyc_i & wb.wbs_stb_i & hit & ~ack_q;
   assign in_win = (wb.wbs_adr_i[7:4] == 4'h0);
   assign ofs    = wb.wbs_adr_i[3:2];

   assign wr_ctrl   = req &  wb.wbs_we_i & in_win & (ofs == 2'd0);
   assign wr_status = req &  wb.wbs_we_i & in_win & (ofs == 2'd1);
   assign wr_din    = req &  wb.wbs_we_i & in_win & (ofs == 2'd2);
   assign rd_dout   = req & ~wb.wbs_we_i & in_win & (ofs == 2'd3);

   assign flush = wr_ctrl & wb.wbs_sel_i[0] & wb.wbs_dat_i[1];

`ifdef WB_ACCEL_LOOPBACK_EN
   logic lb_q;
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i)
         lb_q <= 1'b0;
      else if (wr_ctrl && wb.wbs_sel_i[0])
         lb_q <= wb.wbs_dat_i[4];
   end
   assign lb      = lb_q;
   assign lb_move = lb_q & ~in_empty & ~out_full;
   assign out_din = lb_move ? core_din_o : core_dout_i;
`else
   assign lb      = 1'b0;
   assign lb_move = 1'b0;
   assign out_din = core_dout_i;
`endif

   // Input FIFO: WB pushes, core (or loopback) pops
   assign in_empty         = (in_cnt == '0);
   assign in_full          = (in_cnt == DEPTH);
   assign core_din_o       = in_mem[in_rp];
   assign core_din_valid_o = ~in_empty & ~lb;
   assign in_push          = wr_din & (wb.wbs_sel_i == 4'hF) & ~in_full;
   assign in_pop           = (core_din_valid_o & core_din_ready_i) | lb_move;

   always_ff @(posedge wb_clk_i) begin
      if (in_push && !flush)
         in_mem[in_wp] <= wb.wbs_dat_i;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         in_wp  <= '0;
         in_rp  <= '0;
         in_cnt <= '0;
      end else if (flush) begin
         in_wp  <= '0;
         in_rp  <= '0;
         in_cnt <= '0;
      end else begin
         if (in_push) in_wp <= in_wp + AW'(1);
         if (in_pop)  in_rp <= in_rp + AW'(1);
         case ({in_push, in_pop})
            2'b10:   in_cnt <= in_cnt + LW'(1);
            2'b01:   in_cnt <= in_cnt - LW'(1);
            default: in_cnt <= in_cnt;
         endcase
      end
   end

   // Output FIFO: core (or loopback) pushes, DOUT reads pop
   assign out_empty         = (out_cnt == '0);
   assign out_full          = (out_cnt == DEPTH);
   assign core_dout_ready_o = ~out_full & ~lb;
   assign out_push          = (core_dout_valid_i & core_dout_ready_o) | lb_move;
   assign out_pop           = rd_dout & ~out_empty;

   always_ff @(posedge wb_clk_i) begin
      if (out_push && !flush)
         out_mem[out_wp] <= out_din;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         out_wp  <= '0;
         out_rp  <= '0;
         out_cnt <= '0;
      end else if (flush) begin
         out_wp  <= '0;
         out_rp  <= '0;
         out_cnt <= '0;
      end else begin
         if (out_push) out_wp <= out_wp + AW'(1);
         if (out_pop)  out_rp <= out_rp + AW'(1);
         case ({out_push, out_pop})
            2'b10:   out_cnt <= out_cnt + LW'(1);
            2'b01:   out_cnt <= out_cnt - LW'(1);
            default: out_cnt <= out_cnt;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      if (in_win) begin
         case (ofs)
            2'd0: begin
               rdata[8] = irq_en_q;
               rdata[4] = lb;
            end
            2'd1: begin
               rdata[0]     = core_busy_i;
               rdata[1]     = done_q;
               rdata[2]     = ovf_q;
               rdata[3]     = unf_q;
               rdata[4]     = in_full;
               rdata[5]     = out_empty;
               rdata[11:8]  = 4'(in_cnt);
               rdata[19:16] = 4'(out_cnt);
            end
            2'd3:    rdata = out_empty ? 32'h0 : out_mem[out_rp];
            default: rdata = '0;
         endcase
      end
   end

   // Status flags: a hardware set in the same cycle as a W1C wins
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         ack_q    <= 1'b0;
         dat_q    <= '0;
         start_q  <= 1'b0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         ack_q   <= req;
         start_q <= wr_ctrl & wb.wbs_sel_i[0] & wb.wbs_dat_i[0];
         busy_q  <= core_busy_i;
         if (req)
            dat_q <= wb.wbs_we_i ? 32'h0 : rdata;
         if (wr_ctrl && wb.wbs_sel_i[1])
            irq_en_q <= wb.wbs_dat_i[8];

         if (busy_q && !core_busy_i)
            done_q <= 1'b1;
         else if (wr_status && wb.wbs_sel_i[0] && wb.wbs_dat_i[1])
            done_q <= 1'b0;

         if (wr_din && (wb.wbs_sel_i == 4'hF) && in_full)
            ovf_q <= 1'b1;
         else if (wr_status && wb.wbs_sel_i[0] && wb.wbs_dat_i[2])
            ovf_q <= 1'b0;

         if (rd_dout && out_empty)
            unf_q <= 1'b1;
         else if (wr_status && wb.wbs_sel_i[0] && wb.wbs_dat_i[3])
            unf_q <= 1'b0;
      end
   end

   assign wb.wbs_ack_o = ack_q;
   assign wb.wbs_dat_o = dat_q;
   assign core_start_o = start_q;
   assign irq_o        = done_q & irq_en_q;
endmodule

// File: tb/tb_wb_accel_bridge.sv
// Randomized bench for wb_accel_bridge against a queue-based model of the register window and both FIFOs.
module tb_wb_accel_bridge;
   localparam int          D    = 4;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] core_din;
   logic        core_din_valid;
   logic        core_din_ready = 1'b0;
   logic [31:0] core_dout = '0;
   logic        core_dout_valid = 1'b0;
   logic        core_dout_ready;
   logic        core_start;
   logic        core_busy = 1'b0;
   logic        irq;

   wb_accel_bridge_if wb ();

   always #5 clk = ~clk;

   wb_accel_bridge #(.BASE_ADDR(BASE), .FIFO_DEPTH(D)) dut (
      .wb_clk_i          (clk),
      .wb_rst_n_i        (rst_n),
      .wb                (wb),
      .core_din_o        (core_din),
      .core_din_valid_o  (core_din_valid),
      .core_din_ready_i  (core_din_ready),
      .core_dout_i       (core_dout),
      .core_dout_valid_i (core_dout_valid),
      .core_dout_ready_o (core_dout_ready),
      .core_start_o      (core_start),
      .core_busy_i       (core_busy),
      .irq_o             (irq)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] m_in[$];
   logic [31:0] m_out[$];
   bit m_ovf, m_unf, m_done, m_irq_en;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s        = '0;
      s[0]     = core_busy;
      s[1]     = m_done;
      s[2]     = m_ovf;
      s[3]     = m_unf;
      s[4]     = (m_in.size() == D);
      s[5]     = (m_out.size() == 0);
      s[11:8]  = 4'(m_in.size());
      s[19:16] = 4'(m_out.size());
      return s;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
      wb.wbs_sel_i = '0; wb.wbs_adr_i = '0; wb.wbs_dat_i = '0;
      core_din_ready = 1'b0; core_dout_valid = 1'b0; core_busy = 1'b0;
      m_in.delete(); m_out.delete();
      m_ovf = 0; m_unf = 0; m_done = 0; m_irq_en = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Called and returns at a negedge; drives the request immediately.
   task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input bit expect_ack,
                            output logic [31:0] rdat, output bit start_seen);
      int  cyc;
      bit  got;
      wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
      wb.wbs_adr_i = adr;  wb.wbs_dat_i = dat;  wb.wbs_sel_i = sel;
      got = 0; cyc = 0; rdat = '0; start_seen = 0;
      while (!got && cyc < 8) begin
         @(negedge clk);
         cyc++;
         if (wb.wbs_ack_o) begin
            got = 1;
            rdat = wb.wbs_dat_o;
            start_seen = core_start;
         end
      end
      wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
      if (expect_ack)
         check("ack_latency", got ? 32'(cyc) : 32'hFFFF_FFFF, 32'd1);
      else
         check("nohit_ack", 32'(got), 32'd0);
      @(negedge clk);
      check("ack_one_cycle", 32'(wb.wbs_ack_o), 32'd0);
      check("start_one_cycle", 32'(core_start), 32'd0);
   endtask

   task automatic wb_wr(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel,
                        output bit start_seen);
      logic [31:0] r;
      wb_access(1'b1, BASE | 32'(off), dat, sel, 1'b1, r, start_seen);
   endtask

   task automatic wb_rd(input logic [7:0] off, output logic [31:0] r);
      bit s;
      wb_access(1'b0, BASE | 32'(off), 32'h0, 4'hF, 1'b1, r, s);
   endtask

   task automatic op_din(input logic [31:0] d, input logic [3:0] sel);
      bit s;
      wb_wr(8'h08, d, sel, s);
      if (sel == 4'hF) begin
         if (m_in.size() < D) m_in.push_back(d);
         else                 m_ovf = 1;
      end
   endtask

   task automatic op_dout();
      logic [31:0] r, e;
      wb_rd(8'h0C, r);
      if (m_out.size() > 0) e = m_out.pop_front();
      else begin e = 32'h0; m_unf = 1; end
      check("dout_read", r, e);
   endtask

   task automatic op_status(output logic [31:0] r);
      wb_rd(8'h04, r);
      check("status", r, model_status());
      check("irq", 32'(irq), 32'(m_done & m_irq_en));
   endtask

   task automatic op_w1c(input logic [31:0] v);
      bit s;
      wb_wr(8'h04, v, 4'hF, s);
      if (v[1]) m_done = 0;
      if (v[2]) m_ovf = 0;
      if (v[3]) m_unf = 0;
   endtask

   task automatic op_ctrl(input logic [31:0] d, input logic [3:0] sel);
      bit s;
      wb_wr(8'h00, d, sel, s);
      if (sel[1]) m_irq_en = d[8];
      if (sel[0] && d[1]) begin m_in.delete(); m_out.delete(); end
      check("start_pulse", 32'(s), 32'(sel[0] & d[0]));
   endtask

   task automatic op_ctrl_rd();
      logic [31:0] r;
      wb_rd(8'h00, r);
      check("ctrl_read", r, 32'(m_irq_en) << 8);
   endtask

   task automatic op_core_push(input logic [31:0] d);
      check("dout_ready", 32'(core_dout_ready), 32'(m_out.size() < D));
      core_dout = d; core_dout_valid = 1'b1;
      @(negedge clk);
      core_dout_valid = 1'b0;
      if (m_out.size() < D) m_out.push_back(d);
   endtask

   task automatic op_core_pop();
      check("din_valid", 32'(core_din_valid), 32'(m_in.size() > 0));
      if (m_in.size() > 0) check("din_data", core_din, m_in[0]);
      core_din_ready = 1'b1;
      @(negedge clk);
      core_din_ready = 1'b0;
      if (m_in.size() > 0) void'(m_in.pop_front());
   endtask

   task automatic op_busy();
      logic [31:0] r;
      core_busy = 1'b1;
      @(negedge clk);
      op_status(r);
      core_busy = 1'b0;
      @(negedge clk);
      m_done = 1;
   endtask

   bit lb_mon = 0;
   bit lb_din_seen = 0;
   always @(negedge clk) if (lb_mon && core_din_valid) lb_din_seen = 1;

   initial begin
      logic [31:0] r;
      bit s;
      do_reset();
      check("rst_ack", 32'(wb.wbs_ack_o), 32'd0);
      check("rst_dat", wb.wbs_dat_o, 32'd0);
      check("rst_start", 32'(core_start), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_din_valid", 32'(core_din_valid), 32'd0);
      check("rst_dout_ready", 32'(core_dout_ready), 32'd1);
      op_status(r);
      check("rst_status", r, 32'h0000_0020);

      for (int i = 1; i <= 5; i++) op_din(32'(i), 4'hF);
      op_status(r);
      check("din_full_status", r & 32'h0000_0F14, 32'h0000_0414);
      for (int i = 0; i < 4; i++) op_core_pop();
      op_core_pop();

      op_core_push(32'hA5A5_0001);
      op_core_push(32'hA5A5_0002);
      for (int i = 0; i < 3; i++) op_dout();
      op_status(r);
      check("unf_set", 32'(r[3]), 32'd1);

      op_ctrl(32'h0000_0100, 4'hF);
      op_busy();
      check("irq_on_done", 32'(irq), 32'd1);
      op_w1c(32'h2);
      check("irq_cleared", 32'(irq), 32'd0);
      op_w1c(32'hC);
      op_status(r);

      op_din(32'h1234_5678, 4'h3);
      op_status(r);
      check("partial_sel_no_ovf", 32'(r[2]), 32'd0);
      wb_access(1'b0, 32'h3100_0000, 32'h0, 4'hF, 1'b0, r, s);
      op_din(32'h1111_1111, 4'hF);
      op_core_push(32'h2222_2222);
      op_ctrl(32'h0000_0002, 4'hF);
      op_status(r);
      check("flush_levels", r & 32'h000F_0F00, 32'h0);

      wb_access(1'b1, BASE | 32'h18, 32'hCAFE_F00D, 4'hF, 1'b1, r, s);
      wb_rd(8'h14, r);
      check("oow_read", r, 32'h0);
      op_status(r);

      // hardware done-set colliding with a W1C of done
      core_busy = 1'b1;
      repeat (2) @(negedge clk);
      core_busy = 1'b0;
      wb_wr(8'h04, 32'h2, 4'hF, s);
      m_done = 1;
      op_status(r);
      op_w1c(32'h2);

`ifndef WB_ACCEL_LOOPBACK_EN
      op_ctrl(32'h0000_0010, 4'hF);
      op_ctrl_rd();
`endif

      for (int it = 0; it < 400; it++) begin
         case ($urandom_range(0, 9))
            0, 1: op_din($urandom, ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF);
            2:    op_dout();
            3:    op_core_push($urandom);
            4:    op_core_pop();
            5:    op_status(r);
            6:    op_w1c($urandom & 32'hE);
            7: begin
               logic [31:0] d;
               d = $urandom & 32'h0000_0101;
               if ($urandom_range(0, 7) == 0) d = d | 32'h2;
               op_ctrl(d, 4'($urandom));
            end
            8:    op_ctrl_rd();
            default: op_busy();
         endcase
      end

`ifdef WB_ACCEL_LOOPBACK_EN
      op_ctrl(32'h0000_0002, 4'hF);
      lb_mon = 1;
      wb_wr(8'h00, 32'h0000_0010, 4'hF, s);
      m_irq_en = 0;
      wb_rd(8'h00, r);
      check("lb_ctrl_read", r, 32'h0000_0010);
      check("lb_dout_ready", 32'(core_dout_ready), 32'd0);
      wb_wr(8'h08, 32'hDEAD_BEEF, 4'hF, s);
      repeat (3) @(negedge clk);
      wb_rd(8'h0C, r);
      check("lb_data", r, 32'hDEAD_BEEF);
      check("lb_din_valid_low", 32'(lb_din_seen), 32'd0);
      lb_mon = 0;
      wb_wr(8'h00, 32'h0, 4'hF, s);
`endif

      // reset while an ack is on the bus
      wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
      wb.wbs_adr_i = BASE | 32'h4; wb.wbs_sel_i = 4'hF;
      @(posedge clk);
      #1;
      check("ack_before_reset", 32'(wb.wbs_ack_o), 32'd1);
      rst_n = 1'b0;
      #1;
      check("ack_dropped_by_reset", 32'(wb.wbs_ack_o), 32'd0);
      do_reset();
      op_status(r);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
